// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access with byte-lane steering, load extension,
// acknowledge timeout and flush kill. Optional macro LSU_MISALIGN_EXC_EN traps misaligned accesses.
module load_store_unit #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [3:0]        op_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              exc_o,
    output logic [1:0]        exc_code_o,
    output logic [AW-1:0]     exc_badaddr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int BEW  = DW / 8;
    localparam int OFFW = $clog2(BEW);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic              uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [7:0]        wait_q, wait_d;
    logic              kill_q, kill_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              exc_q, exc_d;
    logic [1:0]        exc_code_q, exc_code_d;
    logic [AW-1:0]     exc_addr_q, exc_addr_d;

    logic              busy, accept, mis_exc, misaligned, timeout;
    logic [1:0]        req_size;
    logic [2:0]        low_mask;
    logic [AW-1:0]     req_addr;
    logic [BEW-1:0]    lane_mask;
    logic [DW-1:0]     rep_wdata;
    logic [DW-1:0]     ld_shift, ld_ext;
    logic [31:0]       ld_bits;
    logic              ld_sign;

    assign busy     = (state_q == BUSY);
    assign req_size = (DW == 32 && op_i[1:0] == 2'd3) ? 2'd2 : op_i[1:0];

    always_comb begin
        case (req_size)
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_EXC_EN
    assign misaligned = |(addr_i[2:0] & low_mask);
    assign req_addr   = addr_i;
`else
    assign misaligned = 1'b0;
    assign req_addr   = {addr_i[AW-1:3], addr_i[2:0] & ~low_mask};
`endif

    assign accept  = ~busy & req_i & ~flush_i & ~misaligned;
    assign mis_exc = ~busy & req_i & ~flush_i & misaligned;
    assign timeout = busy & ~mem_ack_i & (wait_q == 8'(MAX_WAIT - 1));

    // Each byte lane repeats the access-sized chunk of store data; lane enables cover 2^size bytes.
    genvar gi;
    generate
        for (gi = 0; gi < BEW; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            logic [2:0] src;
            assign src                   = LANE & low_mask;
            assign rep_wdata[8*gi +: 8]  = wdata_i[8*src +: 8];
            assign lane_mask[gi]         = (LANE <= low_mask);
        end
    endgenerate

    assign ld_shift = mem_rdata_i >> {addr_q[OFFW-1:0], 3'b000};
    assign ld_bits  = 32'd8 << size_q;

    always_comb begin
        case (size_q)
            2'd0:    ld_sign = ld_shift[7];
            2'd1:    ld_sign = ld_shift[15];
            2'd2:    ld_sign = ld_shift[31];
            default: ld_sign = ld_shift[DW-1];
        endcase
        ld_sign = ld_sign & ~uns_q;
    end

    generate
        for (gi = 0; gi < DW; gi++) begin : g_ext
            localparam int unsigned BIT = gi;
            assign ld_ext[gi] = (BIT < ld_bits) ? ld_shift[gi] : ld_sign;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wait_q     <= 8'd0;
            kill_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= 2'b00;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            kill_q     <= kill_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (mem_ack_i || timeout) state_d = IDLE;
        endcase
    end

    always_comb begin
        store_d    = store_q;
        uns_d      = uns_q;
        size_d     = size_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        kill_d     = kill_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        exc_d      = 1'b0;
        exc_code_d = exc_code_q;
        exc_addr_d = exc_addr_q;
        if (accept) begin
            store_d = op_i[3];
            uns_d   = op_i[2];
            size_d  = req_size;
            addr_d  = req_addr;
            be_d    = lane_mask << req_addr[OFFW-1:0];
            wdata_d = rep_wdata;
            wait_d  = 8'd0;
            kill_d  = 1'b0;
        end
        if (mis_exc) begin
            exc_d      = 1'b1;
            exc_code_d = op_i[3] ? 2'b10 : 2'b01;
            exc_addr_d = addr_i;
        end
        if (busy) begin
            if (flush_i) kill_d = 1'b1;
            if (mem_ack_i) begin
                wait_d = 8'd0;
                kill_d = 1'b0;
                // A flush arriving together with the acknowledge still kills the load result.
                if (!store_q && !kill_q && !flush_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = ld_ext;
                end
            end else if (timeout) begin
                wait_d     = 8'd0;
                kill_d     = 1'b0;
                exc_d      = 1'b1;
                exc_code_d = 2'b11;
                exc_addr_d = addr_q;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    always_comb begin
        stall_o     = accept | (busy & ~mem_ack_i);
        mem_req_o   = busy;
        mem_we_o    = busy & store_q;
        mem_be_o    = busy ? be_q : '0;
        mem_addr_o  = busy ? {addr_q[AW-1:OFFW], {OFFW{1'b0}}} : '0;
        mem_wdata_o = busy ? wdata_q : '0;
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign exc_o         = exc_q;
    assign exc_code_o    = exc_code_q;
    assign exc_badaddr_o = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DW=32, MAX_WAIT=15): directed scenarios plus
// randomized accesses checked against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0, flush_i = 1'b0, mem_ack_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, mem_rdata_i = 32'd0;
    logic        stall_o, rvalid_o, exc_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, exc_badaddr_o, mem_addr_o, mem_wdata_o;
    logic [1:0]  exc_code_o;
    logic [3:0]  mem_be_o;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.DW(32), .AW(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .stall_o(stall_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .exc_o(exc_o),
        .exc_code_o(exc_code_o), .exc_badaddr_o(exc_badaddr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        accept_stall;
        logic        mreq;
        logic        we;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        held_ok;
        logic        ack_stall;
        logic        mreq_after;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rvalid_after;
    } obs_t;

    // ---------------- reference model (DW=32) ----------------
    function automatic int esz(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    function automatic logic [31:0] al_addr(input logic [31:0] a, input logic [1:0] s);
        int n;
        n = 1 << esz(s);
        return a - (a % n);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
        int n, off;
        n   = 1 << esz(s);
        off = int'(al_addr(a, s) % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] s);
        int n;
        longint unsigned r;
        n = 1 << esz(s);
        r = 0;
        for (int k = 0; k < 4; k++)
            r = r | (((longint'(w) >> (8 * (k % n))) & 64'hFF) << (8 * k));
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] r, input logic [31:0] a,
                                            input logic [1:0] s, input logic uns);
        int nb, off;
        longint unsigned v, msk;
        nb  = 8 * (1 << esz(s));
        off = int'(al_addr(a, s) % 4);
        v   = longint'(r) >> (8 * off);
        msk = (64'd1 << nb) - 1;
        v   = v & msk;
        if (!uns && ((v >> (nb - 1)) & 64'd1) == 64'd1) v = v | ~msk;
        return v[31:0];
    endfunction

    // Drives one access (IDLE accept, `delay` unacknowledged BUSY cycles, ack) and records what it saw.
    task automatic drive_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int delay, output obs_t o);
        req_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; flush_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        o.accept_stall = stall_o;
        @(posedge clk); #1;
        o.mreq = mem_req_o; o.we = mem_we_o; o.be = mem_be_o;
        o.maddr = mem_addr_o; o.mwd = mem_wdata_o; o.held_ok = 1'b1;
        for (int i = 0; i < delay; i++) begin
            addr_i = $urandom; wdata_i = $urandom;
            #1;
            if (mem_req_o !== 1'b1 || stall_o !== 1'b1 || mem_be_o !== o.be || mem_addr_o !== o.maddr
                || mem_wdata_o !== o.mwd || mem_we_o !== o.we) o.held_ok = 1'b0;
            @(posedge clk); #1;
        end
        mem_ack_i = 1'b1; mem_rdata_i = rd;
        #1;
        o.ack_stall = stall_o;
        if (mem_req_o !== 1'b1 || mem_be_o !== o.be || mem_addr_o !== o.maddr) o.held_ok = 1'b0;
        @(posedge clk); #1;
        mem_ack_i = 1'b0; req_i = 1'b0; mem_rdata_i = $urandom;
        #1;
        o.rvalid = rvalid_o; o.rdata = rdata_o; o.mreq_after = mem_req_o;
        @(posedge clk); #1;
        o.rvalid_after = rvalid_o;
        $display("txn op=%h addr=%h wdata=%h rdata_in=%h wait=%0d -> be=%h maddr=%h mwd=%h rvalid=%b rdata=%h",
                 op, a, wd, rd, delay, o.be, o.maddr, o.mwd, o.rvalid, o.rdata);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin bad++; $display("FAIL reset_req got req=%b we=%b want 0 0", mem_req_o, mem_we_o); end
        total++; if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_mem got be=%h addr=%h wd=%h want zeros", mem_be_o, mem_addr_o, mem_wdata_o); end
        total++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rd got rvalid=%b rdata=%h want 0 0", rvalid_o, rdata_o); end
        total++; if (exc_o !== 1'b0 || exc_code_o !== 2'b00 || exc_badaddr_o !== 32'h0) begin bad++; $display("FAIL reset_exc got exc=%b code=%b bad=%h want zeros", exc_o, exc_code_o, exc_badaddr_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_sb();
        obs_t o;
        drive_access(4'b1000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, o);
        total++; if (o.maddr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr got %h want 00001000", o.maddr); end
        total++; if (o.be !== 4'b1000) begin bad++; $display("FAIL sb_be got %b want 1000", o.be); end
        total++; if (o.mwd !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got %h want abababab", o.mwd); end
        total++; if (o.we !== 1'b1 || o.mreq !== 1'b1) begin bad++; $display("FAIL sb_we got we=%b req=%b want 1 1", o.we, o.mreq); end
        total++; if (o.rvalid !== 1'b0) begin bad++; $display("FAIL sb_rvalid got %b want 0", o.rvalid); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        drive_access(4'b0000, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, o);
        total++; if (o.rvalid !== 1'b1 || o.rdata !== 32'hFFFF_FFF4) begin bad++; $display("FAIL lb_data got v=%b %h want 1 fffffff4", o.rvalid, o.rdata); end
        total++; if (o.accept_stall !== 1'b1 || o.ack_stall !== 1'b0) begin bad++; $display("FAIL lb_stall got %b/%b want 1/0", o.accept_stall, o.ack_stall); end
        total++; if (o.rvalid_after !== 1'b0) begin bad++; $display("FAIL lb_pulse got %b want 0", o.rvalid_after); end
        drive_access(4'b0100, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, o);
        total++; if (o.rvalid !== 1'b1 || o.rdata !== 32'h0000_00F4) begin bad++; $display("FAIL lbu_data got v=%b %h want 1 000000f4", o.rvalid, o.rdata); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_EXC_EN
        req_i = 1'b1; op_i = 4'b0001; addr_i = 32'h0000_2001; flush_i = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mis_stall got %b want 0", stall_o); end
        @(posedge clk); #1;
        req_i = 1'b0;
        total++; if (exc_o !== 1'b1 || exc_code_o !== 2'b01 || exc_badaddr_o !== 32'h0000_2001) begin bad++; $display("FAIL mis_ld_exc got %b %b %h want 1 01 00002001", exc_o, exc_code_o, exc_badaddr_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL mis_ld_req got %b want 0", mem_req_o); end
        req_i = 1'b1; op_i = 4'b1010; addr_i = 32'h0000_3006;
        @(posedge clk); #1;
        req_i = 1'b0;
        total++; if (exc_o !== 1'b1 || exc_code_o !== 2'b10 || exc_badaddr_o !== 32'h0000_3006 || mem_req_o !== 1'b0) begin bad++; $display("FAIL mis_st_exc got %b %b %h req=%b want 1 10 00003006 0", exc_o, exc_code_o, exc_badaddr_o, mem_req_o); end
        @(posedge clk); #1;
        $display("txn misaligned LH/SW trapped");
`else
        obs_t o;
        drive_access(4'b0001, 32'h0000_2001, 32'h0, 32'h1234_5678, 0, o);
        total++; if (o.maddr !== 32'h0000_2000 || o.be !== 4'b0011) begin bad++; $display("FAIL mis_align got addr=%h be=%b want 00002000 0011", o.maddr, o.be); end
        total++; if (o.rdata !== 32'h0000_5678) begin bad++; $display("FAIL mis_rdata got %h want 00005678", o.rdata); end
        total++; if (exc_o !== 1'b0 || exc_code_o === 2'b01 || exc_code_o === 2'b10) begin bad++; $display("FAIL mis_noexc got exc=%b code=%b want 0 not01/10", exc_o, exc_code_o); end
`endif
    endtask

    task automatic test_timeout();
        int busy_cycles;
        req_i = 1'b1; op_i = 4'b0010; addr_i = 32'h0000_3004; flush_i = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0;
        busy_cycles = 0;
        while (mem_req_o === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        total++; if (busy_cycles != 15) begin bad++; $display("FAIL to_cycles got %0d want 15", busy_cycles); end
        total++; if (exc_o !== 1'b1 || exc_code_o !== 2'b11 || exc_badaddr_o !== 32'h0000_3004) begin bad++; $display("FAIL to_exc got %b %b %h want 1 11 00003004", exc_o, exc_code_o, exc_badaddr_o); end
        total++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL to_idle got stall=%b req=%b want 0 0", stall_o, mem_req_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        total++; if (exc_o !== 1'b0 || exc_code_o !== 2'b11) begin bad++; $display("FAIL to_pulse got exc=%b code=%b want 0 11", exc_o, exc_code_o); end
        total++; if (rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL to_lateack got rvalid=%b req=%b want 0 0", rvalid_o, mem_req_o); end
        @(posedge clk); #1;
        $display("txn LW timeout after %0d busy cycles", busy_cycles);
    endtask

    task automatic test_flush();
        logic held;
        req_i = 1'b1; op_i = 4'b0010; addr_i = 32'h0000_4008; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0; flush_i = 1'b1;
        held = mem_req_o;
        @(posedge clk); #1;
        flush_i = 1'b0;
        held = held & mem_req_o & stall_o;
        @(posedge clk); #1;
        held = held & mem_req_o;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #1;
        total++; if (held !== 1'b1 || mem_addr_o !== 32'h0000_4008) begin bad++; $display("FAIL fl_held got held=%b addr=%h want 1 00004008", held, mem_addr_o); end
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        total++; if (rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL fl_kill got rvalid=%b req=%b want 0 0", rvalid_o, mem_req_o); end
        @(posedge clk); #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL fl_kill2 got %b want 0", rvalid_o); end
        $display("txn LW flushed in busy cycle 1");
    endtask

    task automatic test_async_reset();
        obs_t o;
        req_i = 1'b1; op_i = 4'b0010; addr_i = 32'h0000_5000; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL ar_busy got %b want 1", mem_req_o); end
        #2 rst = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL ar_async got req=%b stall=%b want 0 0", mem_req_o, stall_o); end
        @(posedge clk); #1;
        mem_ack_i = 1'b1;
        @(posedge clk); #1;
        mem_ack_i = 1'b0; rst = 1'b1;
        #1;
        total++; if (exc_o !== 1'b0 || rvalid_o !== 1'b0) begin bad++; $display("FAIL ar_quiet got exc=%b rvalid=%b want 0 0", exc_o, rvalid_o); end
        @(posedge clk); #1;
        drive_access(4'b1010, 32'h0000_5004, 32'hDEAD_BEEF, 32'h0, 1, o);
        total++; if (o.maddr !== 32'h0000_5004 || o.be !== 4'hF || o.mwd !== 32'hDEAD_BEEF || o.we !== 1'b1) begin bad++; $display("FAIL ar_sw got %h %h %h %b want 00005004 f deadbeef 1", o.maddr, o.be, o.mwd, o.we); end
        total++; if (o.held_ok !== 1'b1 || o.mreq_after !== 1'b0 || exc_o !== 1'b0) begin bad++; $display("FAIL ar_sw_done got held=%b req=%b exc=%b want 1 0 0", o.held_ok, o.mreq_after, exc_o); end
    endtask

    task automatic test_back_to_back();
        req_i = 1'b1; op_i = 4'b0010; addr_i = 32'h0000_6000; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_ackstall got %b want 0", stall_o); end
        @(posedge clk); #1;
        mem_ack_i = 1'b0; op_i = 4'b0101; addr_i = 32'h0000_6012;
        #1;
        total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'h1111_2222) begin bad++; $display("FAIL b2b_idle got req=%b stall=%b v=%b rd=%h want 0 1 1 11112222", mem_req_o, stall_o, rvalid_o, rdata_o); end
        @(posedge clk); #1;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_6010 || mem_be_o !== 4'b1100) begin bad++; $display("FAIL b2b_second got req=%b addr=%h be=%b want 1 00006010 1100", mem_req_o, mem_addr_o, mem_be_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_ABCD;
        @(posedge clk); #1;
        mem_ack_i = 1'b0; req_i = 1'b0;
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0000_9999) begin bad++; $display("FAIL b2b_lhu got v=%b rd=%h want 1 00009999", rvalid_o, rdata_o); end
        @(posedge clk); #1;
        $display("txn back-to-back LW then LHU");
    endtask

    task automatic test_random();
        obs_t        o;
        logic [3:0]  op;
        logic [31:0] a, wd, rd, ra;
        int          dly;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 4);
`ifdef LSU_MISALIGN_EXC_EN
            a = al_addr(a, op[1:0]);
`endif
            ra = al_addr(a, op[1:0]);
            drive_access(op, a, wd, rd, dly, o);
            total++; if (o.accept_stall !== 1'b1 || o.mreq !== 1'b1) begin bad++; $display("FAIL rnd%0d_accept got stall=%b req=%b want 1 1", i, o.accept_stall, o.mreq); end
            total++; if (o.we !== op[3]) begin bad++; $display("FAIL rnd%0d_we got %b want %b", i, o.we, op[3]); end
            total++; if (o.maddr !== (ra & ~32'h3)) begin bad++; $display("FAIL rnd%0d_addr got %h want %h", i, o.maddr, ra & ~32'h3); end
            total++; if (o.be !== m_be(a, op[1:0])) begin bad++; $display("FAIL rnd%0d_be got %b want %b", i, o.be, m_be(a, op[1:0])); end
            total++; if (o.mwd !== m_wdata(wd, op[1:0])) begin bad++; $display("FAIL rnd%0d_wdata got %h want %h", i, o.mwd, m_wdata(wd, op[1:0])); end
            total++; if (o.held_ok !== 1'b1 || o.ack_stall !== 1'b0 || o.mreq_after !== 1'b0) begin bad++; $display("FAIL rnd%0d_hold got held=%b ackstall=%b reqafter=%b want 1 0 0", i, o.held_ok, o.ack_stall, o.mreq_after); end
            total++; if (o.rvalid !== ~op[3] || o.rvalid_after !== 1'b0) begin bad++; $display("FAIL rnd%0d_rvalid got %b/%b want %b/0", i, o.rvalid, o.rvalid_after, ~op[3]); end
            if (!op[3]) begin
                total++; if (o.rdata !== m_rdata(rd, a, op[1:0], op[2])) begin bad++; $display("FAIL rnd%0d_rdata got %h want %h", i, o.rdata, m_rdata(rd, a, op[1:0], op[2])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lb_lbu();
        test_misalign();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DW, default 32, data width in bits; legal values are 32 or 64.
REQ-002 Parameter AW, default 32, byte-address width in bits.
REQ-003 Parameter MAX_WAIT, default 15, number of BUSY cycles without an acknowledge before the unit times out; range 1..255.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_i  in  1  memory-stage access valid.
REQ-007 op_i  in  4  {store, unsigned, size[1:0]}; size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DW=64).
REQ-008 addr_i  in  AW  byte address.
REQ-009 wdata_i  in  DW  store data, right-aligned.
REQ-010 flush_i  in  1  kill the current access.
REQ-011 stall_o  out  1  freeze the pipeline stages upstream of this unit.
REQ-012 rvalid_o / rdata_o  out  1 / DW  load result strobe and extended load data.
REQ-013 exc_o / exc_code_o / exc_badaddr_o  out  1 / 2 / AW  exception strobe, code, and faulting address.
REQ-014 mem_req_o, mem_we_o, mem_be_o[DW/8], mem_addr_o[AW], mem_wdata_o[DW]  out  memory request.
REQ-015 mem_ack_i  in  1 / mem_rdata_i  in  DW  memory response.

Function
REQ-016 The FSM shall have two states, IDLE and BUSY; the unit holds at most one outstanding access.
REQ-017 In IDLE, req_i=1 with flush_i=0 and a legal access shall register op, address, and data, then enter BUSY on the next edge.
REQ-018 In BUSY, mem_req_o shall be 1 and all mem_* outputs shall stay constant until the cycle in which mem_ack_i=1.
REQ-019 mem_addr_o shall be the registered address with its low log2(DW/8) bits cleared; with offset = those low bits, mem_be_o = ((1<<2^size)-1) << offset.
REQ-020 mem_wdata_o shall be the low 2^size bytes of wdata replicated across all byte lanes; mem_we_o = store.
REQ-021 On an acknowledged load, rdata_o shall be mem_rdata_i shifted right by offset*8, truncated to the access size, then sign-extended (unsigned=0) or zero-extended (unsigned=1) to DW.
REQ-022 rvalid_o and rdata_o shall be registered: rvalid_o pulses for exactly one cycle, the cycle after the acknowledge; there is no rvalid_o for stores.
REQ-023 stall_o = (IDLE & req_i & ~flush_i) | (BUSY & ~mem_ack_i), combinational; the minimum access takes 2 cycles (accept, then BUSY+ack).
REQ-024 In BUSY, a wait counter shall increment every cycle without an acknowledge; when it reaches MAX_WAIT, the unit shall pulse exc_o with code 2'b11 and the address, drop mem_req_o, and return to IDLE; any later acknowledge for that request is ignored.
REQ-025 flush_i=1 in BUSY shall set a kill flag: mem_req_o stays held until the acknowledge; a killed load produces no rvalid_o; a store already issued completes.
REQ-026 req_i in BUSY shall be ignored because stall_o holds it; an acknowledge and a new req_i in the same cycle are accepted back-to-back (IDLE is entered, and the new request is taken on the following cycle).
REQ-027 A dword op when DW=32 shall be treated as word.
REQ-028 exc_o shall be a one-cycle registered pulse; exc_code_o and exc_badaddr_o hold their values until the next exception.

Reset
REQ-029 With rst=0, the unit shall immediately force: state IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rvalid_o=0, rdata_o=0, exc_o=0, exc_code_o=0, exc_badaddr_o=0, wait counter=0, kill flag=0.
REQ-030 Reset asserted mid-access shall abandon the access with no exception and no rvalid_o.

Configuration
REQ-031 Macro LSU_MISALIGN_EXC_EN defined: an access with addr mod 2^size != 0 shall issue no memory request, pulse exc_o with code 01 (load) or 10 (store) and exc_badaddr_o = addr_i the cycle after req_i, and shall not assert stall_o.
REQ-032 Macro LSU_MISALIGN_EXC_EN undefined: the low size bits of the address shall be forced to zero and the access shall proceed normally; exc_code_o values 01 and 10 never occur.

Verification (DW=32, MAX_WAIT=15)
REQ-033 SB, addr 0x1003, wdata 0x000000AB -> mem_addr_o=0x1000, mem_be_o=4'b1000, mem_wdata_o=0xABABABAB, mem_we_o=1.
REQ-034 LB, then LBU, at 0x2002 with mem_rdata_i=0x12F45678 acknowledged in the first BUSY cycle -> rdata_o=0xFFFFFFF4, then 0x000000F4; rvalid_o one cycle after each acknowledge.
REQ-035 LH at 0x2001 -> with macro: exc_o, code 01, badaddr 0x2001, no mem_req_o; without macro: mem_addr_o=0x2000, mem_be_o=4'b0011.
REQ-036 LW, mem_ack_i held low -> after 15 BUSY cycles: exc_o, code 11, then stall_o=0, mem_req_o=0, state IDLE.
REQ-037 LW, flush_i pulsed in BUSY cycle 1, acknowledge in cycle 3 -> mem_req_o held through cycle 3, no rvalid_o.
REQ-038 rst low in BUSY cycle 2 -> mem_req_o=0 without waiting for clk; after release, a fresh SW completes normally.
